// File: rtl/averaging_scheduler.sv
// averaging_scheduler: round-robin arbiter that lends one shared averaging
// accumulator to a single channel at a time. Each run is clear, sample_count
// gated adds, then show. A run ends early with abort if the granted channel
// drops its request.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no run active; requests sampled, round-robin winner picked
// CLEAR      | clear pulse to the accumulator, sample counter zeroed
// ACCUMULATE | add on every valid sample until sample_count adds are done
// SHOW       | show + acknowledge pulse; winner becomes lowest priority
module averaging_scheduler #(
    parameter int channel_count = 4,
    parameter int channel_bits  = 2,
    parameter int sample_count  = 8,
    parameter int counter_bits  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [channel_count-1:0] request,
    input  logic                     sample_valid,
    output logic [channel_bits-1:0]  channel,
    output logic                     clear,
    output logic                     add,
    output logic                     show,
    output logic                     busy,
    output logic [channel_count-1:0] acknowledge,
    output logic                     abort
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR      = 2'd1,
        ACCUMULATE = 2'd2,
        SHOW       = 2'd3
    } state_t;

    localparam logic [counter_bits-1:0] LAST_CNT = counter_bits'(sample_count - 1);
    localparam logic [channel_bits-1:0] CH_LAST  = channel_bits'(channel_count - 1);

    state_t                    state_q, state_d;
    logic [channel_bits-1:0]   channel_q, channel_d;
    logic [channel_bits-1:0]   last_q, last_d;
    logic [counter_bits-1:0]   count_q, count_d;
    logic                      clear_q, show_q, busy_q, abort_q, abort_d;
    logic [channel_count-1:0]  ack_q, ack_d;

    logic                      found;
    logic [channel_bits-1:0]   winner;
    logic                      req_granted;

    assign req_granted = request[channel_q];

    // Round-robin search starting just after the last served channel.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int i = 1; i <= channel_count; i++) begin
            if (!found && request[(int'(last_q) + i) % channel_count]) begin
                found  = 1'b1;
                winner = channel_bits'((int'(last_q) + i) % channel_count);
            end
        end
    end

    // Next-state, counter, pointer and pulse decode.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        last_d    = last_q;
        count_d   = count_q;
        abort_d   = 1'b0;
        ack_d     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    channel_d = winner;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                count_d = '0;
                if (!req_granted) begin
                    abort_d = 1'b1;
                    last_d  = channel_q;
                    state_d = IDLE;
                end else begin
                    state_d = ACCUMULATE;
                end
            end
            ACCUMULATE: begin
                if (!req_granted) begin
                    abort_d = 1'b1;
                    last_d  = channel_q;
                    state_d = IDLE;
                end else if (sample_valid) begin
                    if (count_q == LAST_CNT) begin
                        // Final add: park the counter at zero instead of letting it overrun.
                        count_d = '0;
                        state_d = SHOW;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            SHOW: begin
                last_d  = channel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == SHOW) begin
            ack_d[channel_d] = 1'b1;
        end
    end

    // State, pointer, counter and registered Moore outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            channel_q <= '0;
            last_q    <= CH_LAST;
            count_q   <= '0;
            clear_q   <= 1'b0;
            show_q    <= 1'b0;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            last_q    <= last_d;
            count_q   <= count_d;
            clear_q   <= (state_d == CLEAR);
            show_q    <= (state_d == SHOW);
            busy_q    <= (state_d != IDLE);
            abort_q   <= abort_d;
            ack_q     <= ack_d;
        end
    end

    assign add         = (state_q == ACCUMULATE) & sample_valid & req_granted;
    assign channel     = channel_q;
    assign clear       = clear_q;
    assign show        = show_q;
    assign busy        = busy_q;
    assign abort       = abort_q;
    assign acknowledge = ack_q;

endmodule

// File: tb/tb_averaging_scheduler.sv
// Bench for averaging_scheduler: scoreboard of expected show/abort events
// plus cycle-exact checks on latency, abort, reset and a 2-channel/1-sample build.
module tb_averaging_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic       sample_valid;
    logic [1:0] channel;
    logic       clear, add, show, busy, abort;
    logic [3:0] acknowledge;

    logic [1:0] request1;
    logic       sample_valid1;
    logic [0:0] channel1;
    logic       clear1, add1, show1, busy1, abort1;
    logic [1:0] acknowledge1;

    averaging_scheduler #(
        .channel_count(4), .channel_bits(2), .sample_count(8), .counter_bits(4)
    ) u0 (
        .clock(clock), .reset(reset), .request(request), .sample_valid(sample_valid),
        .channel(channel), .clear(clear), .add(add), .show(show), .busy(busy),
        .acknowledge(acknowledge), .abort(abort)
    );

    averaging_scheduler #(
        .channel_count(2), .channel_bits(1), .sample_count(1), .counter_bits(1)
    ) u1 (
        .clock(clock), .reset(reset), .request(request1), .sample_valid(sample_valid1),
        .channel(channel1), .clear(clear1), .add(add1), .show(show1), .busy(busy1),
        .acknowledge(acknowledge1), .abort(abort1)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit is_abort;
        int ch;
        int adds;
    } evt_t;

    evt_t exp_q[$];
    evt_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pops = 0;
    int   adds_seen = 0;
    int   cyc = 0;
    int   last_show_cyc = 0;
    bit   gap_en = 1'b0;
    bit   have_show = 1'b0;
    int   k, a, pops_before;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_evt(input bit is_abort, input int ch, input int adds);
        evt_t x;
        x.is_abort = is_abort;
        x.ch = ch;
        x.adds = adds;
        exp_q.push_back(x);
    endtask

    task automatic set_in(input logic [3:0] r, input logic v);
        @(posedge clock);
        #1;
        request = r;
        sample_valid = v;
    endtask

    task automatic wait_pops(input string tag, input int target, input int budget);
        int i = 0;
        while (pops < target && i < budget) begin
            @(posedge clock);
            i++;
        end
        check_val(tag, pops, target);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        request = '0;
        sample_valid = 1'b0;
        request1 = '0;
        sample_valid1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: counts adds per run, pops the scoreboard on every show/abort.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (clear) begin
                adds_seen = 0;
                if (gap_en && have_show) check_val("rr_gap_show_to_clear", cyc - last_show_cyc, 2);
            end
            if (add) adds_seen++;
            if (show || abort) begin
                check_val("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    pops++;
                    check_val("evt_kind_abort", abort, e.is_abort);
                    check_val("evt_channel", channel, e.ch);
                    check_val("evt_ack", acknowledge, e.is_abort ? 0 : (1 << e.ch));
                    check_val("evt_adds", adds_seen, e.adds);
                end
                if (show) begin
                    last_show_cyc = cyc;
                    have_show = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        request = '0;
        sample_valid = 1'b0;
        request1 = '0;
        sample_valid1 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check_val("rst_busy", busy, 0);
        check_val("rst_channel", channel, 0);
        check_val("rst_pulses", {clear, add, show, abort}, 0);
        check_val("rst_ack", acknowledge, 0);
        check_val("rst_u1_busy", busy1, 0);

        // Single channel latency
        push_evt(1'b0, 0, 8);
        set_in(4'b0001, 1'b1);
        @(negedge clock);
        check_val("t1_idle_clear", clear, 0);
        check_val("t1_idle_busy", busy, 0);
        @(negedge clock);
        check_val("t1_clear", clear, 1);
        check_val("t1_clear_busy", busy, 1);
        check_val("t1_clear_add", add, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_val("t1_add", add, 1);
            check_val("t1_add_clear", clear, 0);
        end
        @(negedge clock);
        check_val("t1_show", show, 1);
        check_val("t1_ack", acknowledge, 4'b0001);
        check_val("t1_show_add", add, 0);
        @(posedge clock);
        #1;
        request = '0;
        @(negedge clock);
        check_val("t1_busy_low", busy, 0);
        check_val("t1_show_low", show, 0);

        // Round-robin from a fresh pointer
        do_reset();
        gap_en = 1'b1;
        have_show = 1'b0;
        push_evt(1'b0, 0, 8);
        push_evt(1'b0, 1, 8);
        push_evt(1'b0, 2, 8);
        push_evt(1'b0, 3, 8);
        push_evt(1'b0, 0, 8);
        pops_before = pops;
        set_in(4'b1111, 1'b1);
        wait_pops("rr_five_runs", pops_before + 5, 200);
        #1;
        request = '0;
        gap_en = 1'b0;

        // Stalling with alternating sample_valid
        push_evt(1'b0, 0, 8);
        pops_before = pops;
        set_in(4'b0001, 1'b1);
        k = 0;
        while (pops < pops_before + 1 && k < 100) begin
            @(negedge clock);
            check_val("stall_add_gated", add & ~sample_valid, 0);
            @(posedge clock);
            #1;
            sample_valid = ~sample_valid;
            k++;
        end
        check_val("stall_done", pops, pops_before + 1);
        request = '0;

        // Abort after three adds on channel 2
        push_evt(1'b1, 2, 3);
        set_in(4'b0100, 1'b1);
        k = 0;
        while (!clear && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_val("ab_clear_seen", clear, 1);
        check_val("ab_channel", channel, 2);
        a = 0;
        k = 0;
        while (a < 3 && k < 20) begin
            @(negedge clock);
            k++;
            if (add) a++;
        end
        check_val("ab_three_adds", a, 3);
        @(posedge clock);
        #1;
        request = '0;
        @(negedge clock);
        check_val("ab_no_add", add, 0);
        check_val("ab_no_early_abort", abort, 0);
        @(negedge clock);
        check_val("ab_abort", abort, 1);
        check_val("ab_busy", busy, 0);
        check_val("ab_no_show", show, 0);
        check_val("ab_no_ack", acknowledge, 0);
        @(negedge clock);
        check_val("ab_abort_one_cycle", abort, 0);
        push_evt(1'b0, 0, 8);
        push_evt(1'b0, 2, 8);
        pops_before = pops;
        set_in(4'b0101, 1'b1);
        wait_pops("ab_regrant", pops_before + 2, 100);
        #1;
        request = '0;

        // Reset in the middle of a run on channel 3
        pops_before = pops;
        set_in(4'b1000, 1'b1);
        k = 0;
        while (!(add && channel == 2'd3) && k < 20) begin
            @(negedge clock);
            k++;
        end
        check_val("rst_mid_running", {add, channel}, {1'b1, 2'd3});
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        request = '0;
        sample_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_channel", channel, 0);
        check_val("rst_mid_pulses", {clear, add, show, abort}, 0);
        check_val("rst_mid_ack", acknowledge, 0);
        @(negedge clock);
        check_val("rst_mid_no_abort", abort, 0);
        check_val("rst_mid_no_evt", pops, pops_before);
        push_evt(1'b0, 0, 8);
        push_evt(1'b0, 3, 8);
        set_in(4'b1001, 1'b1);
        wait_pops("rst_regrant", pops_before + 2, 100);
        #1;
        request = '0;

        // Two channels, one sample per run
        @(posedge clock);
        #1;
        request1 = 2'b10;
        sample_valid1 = 1'b1;
        @(negedge clock);
        check_val("u1_idle_clear", clear1, 0);
        @(negedge clock);
        check_val("u1_clear", clear1, 1);
        check_val("u1_channel", channel1, 1);
        @(negedge clock);
        check_val("u1_add", add1, 1);
        check_val("u1_add_show", show1, 0);
        @(negedge clock);
        check_val("u1_show", show1, 1);
        check_val("u1_ack", acknowledge1, 2'b10);
        check_val("u1_show_add", add1, 0);
        @(posedge clock);
        #1;
        request1 = '0;
        @(negedge clock);
        check_val("u1_busy_low", busy1, 0);

        repeat (3) @(negedge clock);
        check_val("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
